// File: rtl/srch_pkg.sv
// Shared types and sizing helpers for the search table engine.
package srch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  // Width needed to hold a count from 0 up to and including depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/srch_lane_cmp.sv
// Combinational comparator bank for one scan group of LANES table entries.
module srch_lane_cmp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LANES  = 4,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int PW    = $clog2(LANES) + 1
) (
  input  logic [LANES*DATA_W-1:0] lane_data,
  input  logic [LANES*ADDR_W-1:0] lane_addr,
  input  logic [LANES-1:0]        lane_valid,
  input  logic [DATA_W-1:0]       key,
  output logic [LANES-1:0]        match,
  output logic [LW-1:0]           win_idx,
  output logic [ADDR_W-1:0]       win_addr,
  output logic [PW-1:0]           pop
);

  // Walk lanes from high to low so the lowest matching lane is the last writer.
  always_comb begin
    match    = '0;
    win_idx  = '0;
    win_addr = '0;
    pop      = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_valid[l] && (lane_data[l*DATA_W +: DATA_W] == key)) begin
        match[l] = 1'b1;
        win_idx  = LW'(l);
        win_addr = lane_addr[l*ADDR_W +: ADDR_W];
        pop      = pop + PW'(1);
      end
    end
  end

endmodule

// File: rtl/srch_table_engine.sv
// Append-only (data, address) table with a multi-lane first/all-match search.
module srch_table_engine
  import srch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16,
  parameter int LANES  = 4,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              dtin,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] address,
  input  logic              srch,
  input  logic [DATA_W-1:0] srdt,
  input  logic              m_all,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              busy,
  output logic              op_sr,
  output logic              hit,
  output logic [ADDR_W-1:0] out_mem_ad,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = $clog2(LANES) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    base_q, base_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic                mode_q, mode_d;
  logic                hit_q, hit_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    hcnt_q, hcnt_d;
  logic                wr_en;
  logic                full_w;

  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [ADDR_W-1:0]   addr_mem [DEPTH];

  logic [LANES*DATA_W-1:0] lane_data;
  logic [LANES*ADDR_W-1:0] lane_addr;
  logic [LANES-1:0]        lane_valid;
  logic [LANES-1:0]        lane_match;
  logic [LW-1:0]           win_idx;
  logic [ADDR_W-1:0]       win_addr;
  logic [PW-1:0]           pop;
  logic                    grp_any;

  assign full_w = (count_q == CNT_W'(DEPTH));

  // Parallel read of the current group; base stays LANES-aligned so no wrap occurs.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CNT_W-1:0] idx;
    assign idx = base_q + CNT_W'(l);
    assign lane_data[l*DATA_W +: DATA_W] = data_mem[idx[IW-1:0]];
    assign lane_addr[l*ADDR_W +: ADDR_W] = addr_mem[idx[IW-1:0]];
    assign lane_valid[l] = (idx < count_q);
  end

  srch_lane_cmp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_cmp (
    .lane_data  (lane_data),
    .lane_addr  (lane_addr),
    .lane_valid (lane_valid),
    .key        (key_q),
    .match      (lane_match),
    .win_idx    (win_idx),
    .win_addr   (win_addr),
    .pop        (pop)
  );

  assign grp_any = |lane_match;

  // Next-state and result update; IDLE priority is clr, then srch, then dtin.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    base_d  = base_q;
    key_d   = key_q;
    mode_d  = mode_q;
    hit_d   = hit_q;
    addr_d  = addr_q;
    hcnt_d  = hcnt_q;
    wr_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (clr) begin
          count_d = '0;
        end else if (srch) begin
          key_d   = srdt;
          mode_d  = m_all;
          base_d  = '0;
          hit_d   = 1'b0;
          addr_d  = '0;
          hcnt_d  = '0;
          state_d = (count_q != '0) ? StScan : StDone;
        end else if (dtin && !full_w) begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      StScan: begin
        if (!hit_q && grp_any) begin
          hit_d  = 1'b1;
          addr_d = win_addr;
        end
        if (!mode_q && grp_any) begin
          hcnt_d  = CNT_W'(1);
          state_d = StDone;
        end else begin
          if (mode_q) begin
            hcnt_d = hcnt_q + CNT_W'(pop);
          end
          if (({1'b0, base_q} + (CNT_W + 1)'(LANES)) >= {1'b0, count_q}) begin
            state_d = StDone;
          end else begin
            base_d = base_q + CNT_W'(LANES);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      base_q  <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      base_q  <= base_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      hit_q   <= hit_d;
      addr_q  <= addr_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Table storage is deliberately not reset; entries past count are never compared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[count_q[IW-1:0]] <= data;
      addr_mem[count_q[IW-1:0]] <= address;
    end
  end

  // The reported winner lane must always be one of the matching lanes.
  always_ff @(posedge clk) begin
    if (reset && (state_q == StScan) && grp_any) begin
      assert (lane_match[win_idx]);
    end
  end

  assign count      = count_q;
  assign full       = full_w;
  assign busy       = (state_q != StIdle);
  assign op_sr      = (state_q == StDone);
  assign hit        = hit_q;
  assign out_mem_ad = addr_q;
  assign hit_cnt    = hcnt_q;

endmodule

// File: tb/tb_srch_table_engine.sv
// Self-checking bench for srch_table_engine against a queue-based table model.
module tb_srch_table_engine;

  localparam int DEPTH = 16;
  localparam int LANES = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       dtin;
  logic [7:0] data;
  logic [7:0] address;
  logic       srch;
  logic [7:0] srdt;
  logic       m_all;
  logic [4:0] count;
  logic       full;
  logic       busy;
  logic       op_sr;
  logic       hit;
  logic [7:0] out_mem_ad;
  logic [4:0] hit_cnt;

  int passed = 0;
  int total  = 0;

  logic [7:0] m_data[$];
  logic [7:0] m_addr[$];

  always #5 clk = ~clk;

  srch_table_engine #(
    .DATA_W (8),
    .ADDR_W (8),
    .DEPTH  (DEPTH),
    .LANES  (LANES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .dtin       (dtin),
    .data       (data),
    .address    (address),
    .srch       (srch),
    .srdt       (srdt),
    .m_all      (m_all),
    .count      (count),
    .full       (full),
    .busy       (busy),
    .op_sr      (op_sr),
    .hit        (hit),
    .out_mem_ad (out_mem_ad),
    .hit_cnt    (hit_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d, input logic [7:0] a);
    dtin = 1'b1; data = d; address = a;
    step();
    dtin = 1'b0;
    if (m_data.size() < DEPTH) begin
      m_data.push_back(d);
      m_addr.push_back(a);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_data.delete();
    m_addr.delete();
  endtask

  // Returns the cycle (edge 0 = srch sample) in which op_sr is seen; 999 on timeout.
  task automatic do_search(input logic [7:0] key, input logic mode, output int cyc);
    srch = 1'b1; srdt = key; m_all = mode;
    step();
    srch = 1'b0;
    cyc = 1;
    while (op_sr !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    if (op_sr !== 1'b1) cyc = 999;
  endtask

  // Expected result straight from the table contents and the group-scan rule.
  function automatic void model(input logic [7:0] key, input logic mode, output logic e_hit,
                                output logic [7:0] e_addr, output int e_cnt, output int e_cyc);
    int n, first, groups;
    n = m_data.size();
    first = -1;
    e_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (m_data[i] == key) begin
        if (first < 0) first = i;
        e_cnt++;
      end
    end
    e_hit  = (first >= 0);
    e_addr = e_hit ? m_addr[first] : 8'h00;
    if (!mode) begin
      e_cnt  = e_hit ? 1 : 0;
      groups = e_hit ? (first / LANES + 1) : ((n + LANES - 1) / LANES);
    end else begin
      groups = (n + LANES - 1) / LANES;
    end
    e_cyc = groups + 1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    total++;
    if ({count, full, busy, op_sr, hit, out_mem_ad, hit_cnt} !== 23'h0) begin
      $display("FAIL reset_state: got count=%0d full=%b busy=%b op_sr=%b hit=%b ad=%h hc=%0d, want all 0",
               count, full, busy, op_sr, hit, out_mem_ad, hit_cnt);
    end else passed++;
    reset = 1'b1;
    step();
    m_data.delete();
    m_addr.delete();
  endtask

  task automatic check_search(input string name, input logic [7:0] key, input logic mode);
    int cyc, e_cnt, e_cyc;
    logic e_hit;
    logic [7:0] e_addr;
    model(key, mode, e_hit, e_addr, e_cnt, e_cyc);
    do_search(key, mode, cyc);
    total++;
    if (cyc !== e_cyc || hit !== e_hit || out_mem_ad !== e_addr || hit_cnt !== 5'(e_cnt)) begin
      $display("FAIL %s: got cyc=%0d hit=%b ad=%h hc=%0d, want cyc=%0d hit=%b ad=%h hc=%0d",
               name, cyc, hit, out_mem_ad, hit_cnt, e_cyc, e_hit, e_addr, e_cnt);
    end else passed++;
    step();
    total++;
    if (op_sr !== 1'b0 || busy !== 1'b0 || hit !== e_hit || hit_cnt !== 5'(e_cnt)) begin
      $display("FAIL %s_after: got op_sr=%b busy=%b hit=%b hc=%0d, want 0 0 %b %0d",
               name, op_sr, busy, hit, hit_cnt, e_hit, e_cnt);
    end else passed++;
  endtask

  task automatic test_first_match();
    logic [7:0] d [5] = '{8'h11, 8'h22, 8'h33, 8'h22, 8'h44};
    for (int i = 0; i < 5; i++) do_write(d[i], 8'hA0 + 8'(i));
    total++;
    if (count !== 5'd5 || full !== 1'b0) begin
      $display("FAIL load5: got count=%0d full=%b, want 5 0", count, full);
    end else passed++;
    check_search("first_match", 8'h22, 1'b0);
  endtask

  task automatic test_all_match();
    check_search("all_match", 8'h22, 1'b1);
    check_search("all_match_last", 8'h44, 1'b1);
  endtask

  task automatic test_no_match();
    check_search("no_match", 8'h55, 1'b0);
    check_search("no_match_all", 8'h55, 1'b1);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    srch = 1'b1; srdt = 8'h22; m_all = 1'b1;
    step();
    srch = 1'b0; dtin = 1'b1; data = 8'h22; address = 8'hEE;
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_rise: got busy=%b, want 1", busy);
    end else passed++;
    cyc = 1;
    while (op_sr !== 1'b1 && cyc < 200) begin step(); cyc++; end
    dtin = 1'b0;
    step();
    total++;
    if (count !== 5'd5 || hit_cnt !== 5'd2) begin
      $display("FAIL dtin_busy: got count=%0d hc=%0d, want 5 2", count, hit_cnt);
    end else passed++;
    // clr held through a whole search must also be ignored.
    srch = 1'b1; srdt = 8'h11; m_all = 1'b0;
    step();
    srch = 1'b0; clr = 1'b1;
    cyc = 1;
    while (op_sr !== 1'b1 && cyc < 200) begin step(); cyc++; end
    clr = 1'b0;
    step();
    total++;
    if (count !== 5'd5 || hit !== 1'b1 || out_mem_ad !== 8'hA0) begin
      $display("FAIL clr_busy: got count=%0d hit=%b ad=%h, want 5 1 a0", count, hit, out_mem_ad);
    end else passed++;
  endtask

  task automatic test_srch_dtin();
    int cyc;
    srch = 1'b1; srdt = 8'h33; m_all = 1'b1;
    dtin = 1'b1; data = 8'h33; address = 8'hEF;
    step();
    srch = 1'b0; dtin = 1'b0;
    cyc = 1;
    while (op_sr !== 1'b1 && cyc < 200) begin step(); cyc++; end
    total++;
    if (count !== 5'd5 || hit_cnt !== 5'd1 || out_mem_ad !== 8'hA2 || cyc !== 3) begin
      $display("FAIL srch_dtin: got count=%0d hc=%0d ad=%h cyc=%0d, want 5 1 a2 3",
               count, hit_cnt, out_mem_ad, cyc);
    end else passed++;
    step();
  endtask

  task automatic test_clr_srch();
    clr = 1'b1; srch = 1'b1; srdt = 8'h11; m_all = 1'b0;
    step();
    clr = 1'b0; srch = 1'b0;
    m_data.delete();
    m_addr.delete();
    total++;
    if (count !== 5'd0 || busy !== 1'b0 || op_sr !== 1'b0) begin
      $display("FAIL clr_srch: got count=%0d busy=%b op_sr=%b, want 0 0 0", count, busy, op_sr);
    end else passed++;
    step();
    total++;
    if (op_sr !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL clr_srch_idle: got op_sr=%b busy=%b, want 0 0", op_sr, busy);
    end else passed++;
  endtask

  task automatic test_empty_full();
    check_search("empty", 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_write(8'h80 + 8'(i), 8'(i));
    total++;
    if (count !== 5'd16 || full !== 1'b1) begin
      $display("FAIL fill16: got count=%0d full=%b, want 16 1", count, full);
    end else passed++;
    do_write(8'h8F, 8'h77);
    total++;
    if (count !== 5'd16 || full !== 1'b1) begin
      $display("FAIL write17: got count=%0d full=%b, want 16 1", count, full);
    end else passed++;
    check_search("last_entry", 8'h8F, 1'b0);
    check_search("full_all", 8'h8F, 1'b1);
  endtask

  task automatic test_reset_midscan();
    int seen;
    do_clr();
    for (int i = 0; i < DEPTH; i++) do_write(8'h00, 8'(i));
    srch = 1'b1; srdt = 8'h01; m_all = 1'b1;
    step();
    srch = 1'b0;
    step();
    reset = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || count !== 5'd0 || op_sr !== 1'b0) begin
      $display("FAIL reset_midscan: got busy=%b count=%0d op_sr=%b, want 0 0 0", busy, count, op_sr);
    end else passed++;
    reset = 1'b1;
    m_data.delete();
    m_addr.delete();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (op_sr === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      $display("FAIL reset_no_done: got %0d active cycles, want 0", seen);
    end else passed++;
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 25; it++) begin
      do_clr();
      n = $urandom_range(0, DEPTH);
      for (int i = 0; i < n; i++) do_write(8'($urandom_range(0, 3)), 8'($urandom));
      total++;
      if (count !== 5'(n) || full !== (n == DEPTH)) begin
        $display("FAIL rand_count: got count=%0d full=%b, want %0d %b", count, full, n, n == DEPTH);
      end else passed++;
      for (int s = 0; s < 3; s++) begin
        check_search("rand_search", 8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; dtin = 1'b0; data = '0; address = '0;
    srch = 1'b0; srdt = '0; m_all = 1'b0;
    #1;
    test_reset();
    test_first_match();
    test_all_match();
    test_no_match();
    test_busy_ignore();
    test_srch_dtin();
    test_clr_srch();
    test_empty_full();
    test_reset_midscan();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/srch_table_engine.md
# srch_table_engine

Parametrised successor to the 8-bit data/address search unit. It stores up to DEPTH (data, address) pairs in an append-only table. On request it scans the table for a key, comparing LANES entries per cycle. It returns the address of the first match, or, in all-match mode, the first address plus the total hit count, and pulses a done strobe. It sits between the host-side load/search controls and downstream logic that consumes the matched memory address.

## Interface
- DATA_W, 8, width of stored data and search key
- ADDR_W, 8, width of stored address
- DEPTH, 16, table entries; power of two, ≥ LANES
- LANES, 4, comparators per scan cycle; power of two, divides DEPTH
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; one clock, synchronous active-low reset
- clr  in  1  empty table (count ← 0)
- dtin  in  1  write strobe: append {data, address} at index count
- data  in  DATA_W  entry data
- address  in  ADDR_W  entry address
- srch  in  1  start search; samples srdt and m_all
- srdt  in  DATA_W  search key
- m_all  in  1  0 = first-match mode, 1 = all-match mode
- count  out  CNT_W  valid entries, 0..DEPTH; CNT_W = $clog2(DEPTH)+1
- full  out  1  count == DEPTH
- busy  out  1  search in progress
- op_sr  out  1  one-cycle done pulse
- hit  out  1  at least one match found
- out_mem_ad  out  ADDR_W  address field of lowest-index matching entry, 0 if no hit
- hit_cnt  out  CNT_W  number of matches; in first-match mode 0 or 1

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE handling, by priority:
  - clr: count ← 0.
  - srch: latch key and mode, base ← 0, clear hit/hit_cnt/out_mem_ad. Go to SCAN if count > 0, else go to DONE.
  - dtin with !full: write entry[count], count ← count+1.
- Same-cycle priority in IDLE: clr > srch > dtin. A lower-priority request is dropped, not queued.
- SCAN, each cycle, group g covers indices base..base+LANES-1:
  - A lane is valid only if index < count.
  - Matching lane: valid and data == key.
  - The lowest-index match in the group is the group winner.
  - If hit was 0 and the group has a winner: hit ← 1, out_mem_ad ← winner address.
  - First-match mode: any match in the group → hit_cnt ← 1, go to DONE.
  - All-match mode: hit_cnt += popcount(matching lanes).
  - If base+LANES ≥ count, go to DONE; else base += LANES.
- DONE: op_sr = 1 for exactly one cycle, then go to IDLE.
- Results (hit, out_mem_ad, hit_cnt) hold until the next accepted srch or reset.
- While busy (SCAN/DONE), srch, dtin and clr are ignored. The table is frozen during a search.
- dtin when full is ignored; count saturates at DEPTH.
- hit_cnt cannot overflow: its maximum is DEPTH, which fits in CNT_W.

## Timing
- Reset values: count 0, full 0, busy 0, op_sr 0, hit 0, out_mem_ad 0, hit_cnt 0, state IDLE.
- Table storage is not reset; entries at index ≥ count are never compared.
- Write: count/full update on the edge sampling dtin; the new entry is searchable from the next cycle.
- busy = 1 in SCAN and DONE; it rises the cycle after srch is sampled.
- Search latency:
  - srch sampled at edge 0 → op_sr high in cycle G+1, where G is the number of groups scanned.
  - All-match mode: G = ceil(count/LANES).
  - First-match mode: G = index of the first group with a match, plus 1.
  - Empty table: G = 0, op_sr in cycle 1, hit 0.
- Results are valid in the cycle op_sr is high and after. A new srch is accepted in the cycle after op_sr.
- reset low in any state, including mid-SCAN, aborts the search without an op_sr pulse and empties the table.

## Structure
- Package srch_pkg holds:
  - state enum (IDLE, SCAN, DONE)
  - CNT_W helper function
- Top srch_table_engine contains the FSM, the table as a flop array (LANES parallel reads), count, base and result registers.
- Sub-module srch_lane_cmp is combinational. Inputs: LANES entries, valid mask, key. Outputs: match vector, lowest-index winner, winner address, popcount.

## Test plan
- Load 5 entries (data 0x11,0x22,0x33,0x22,0x44 / address 0xA0..0xA4), search key 0x22, m_all=0 → op_sr in cycle 2, hit 1, out_mem_ad 0xA1, hit_cnt 1.
- Same table, key 0x22, m_all=1 → op_sr in cycle 3 (G=2), out_mem_ad 0xA1, hit_cnt 2.
- Key 0x55 not in table, m_all=0 → full scan, hit 0, out_mem_ad 0, hit_cnt 0.
- Search on empty table → op_sr in cycle 1, hit 0. Then a 17th dtin after 16 writes → count stays 16, full 1.
- Edge cases:
  - dtin during busy → count unchanged.
  - srch and dtin in the same IDLE cycle → dtin dropped.
  - clr and srch in the same cycle → count 0, no search.
- reset asserted mid-SCAN (DEPTH=16, all entries 0x00, key 0x01, m_all=1) → next cycle busy 0, count 0, no op_sr pulse.
